// File: rtl/multiply_ctrl_banked_if.sv
// Datapath-side bus of multiply_ctrl_banked: BRAM read ports, the Input_align
// beat stream and the per-bank Align_fifo programming/drain signals.
// The controller uses the master modport; the datapath side uses slave.
interface multiply_ctrl_banked_if #(
    parameter int ARR_M     = 8,
    parameter int ARR_P     = 8,
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = 32
);
    logic [ADDR_W-1:0]              fm_addr;
    logic [ARR_M*8-1:0]             fm_rddata;
    logic [ADDR_W-1:0]              wm_addr;
    logic [NUM_BANKS*ARR_P*8-1:0]   wm_rddata;
    logic [ARR_M-1:0]               fvalid;
    logic [NUM_BANKS*ARR_P-1:0]     wvalid;
    logic [ARR_M*8-1:0]             fdata;
    logic [NUM_BANKS*ARR_P*8-1:0]   wdata;
    logic                           num_valid;
    logic [15:0]                    num_ori;
    logic [NUM_BANKS*8-1:0]         sub_scale_M;
    logic [NUM_BANKS*8-1:0]         sub_scale_P;
    logic [NUM_BANKS-1:0]           bank_get_all;

    modport master (
        output fm_addr, wm_addr, fvalid, wvalid, fdata, wdata,
               num_valid, num_ori, sub_scale_M, sub_scale_P,
        input  fm_rddata, wm_rddata, bank_get_all
    );

    modport slave (
        input  fm_addr, wm_addr, fvalid, wvalid, fdata, wdata,
               num_valid, num_ori, sub_scale_M, sub_scale_P,
        output fm_rddata, wm_rddata, bank_get_all
    );
endinterface

// File: rtl/multiply_ctrl_banked.sv
// Submatrix multiply sequencer: streams N feature/weight rows from BRAM into
// Input_align, programs per-bank Align_fifo scales and waits for every active
// bank to drain before pulsing finish.
// Optional WAIT watchdog is built when MULTI_CTRL_WDT_EN is defined.
module multiply_ctrl_banked #(
    parameter int ARR_M      = 8,
    parameter int ARR_P      = 8,
    parameter int NUM_BANKS  = 2,
    parameter int RD_LAT     = 1,
    parameter int ADDR_W     = 32,
    parameter int SADDR_F    = 0,
    parameter int SADDR_W    = 0,
    parameter int F_INCR     = 8,
    parameter int W_INCR     = 16,
    parameter int WDT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            sub_M,
    input  logic [7:0]            sub_P,
    input  logic [15:0]           N,
    input  logic [15:0]           subFM_addr,
    input  logic [15:0]           subFM_incr,
    input  logic [15:0]           subWM_addr,
    input  logic [15:0]           subWM_incr,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  stall,
    output logic                  busy,
    output logic                  finish,
    output logic                  err_timeout,
    multiply_ctrl_banked_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INFO   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [ADDR_W-1:0] F_BASE = ADDR_W'(SADDR_F);
    localparam logic [ADDR_W-1:0] W_BASE = ADDR_W'(SADDR_W);
    localparam logic [ADDR_W-1:0] F_MUL  = ADDR_W'(F_INCR);
    localparam logic [ADDR_W-1:0] W_MUL  = ADDR_W'(W_INCR);

    logic [2:0]             state;
    logic [7:0]             cfg_m;
    logic [7:0]             cfg_p;
    logic [15:0]            cfg_n;
    logic [15:0]            issue_cnt;
    logic [ADDR_W-1:0]      fm_step;
    logic [ADDR_W-1:0]      wm_step;
    logic [NUM_BANKS-1:0]   done;
    logic [NUM_BANKS-1:0]   done_nxt;
    logic [NUM_BANKS-1:0]   done_pre;
    logic [NUM_BANKS*8-1:0] scale_p_nxt;
    logic [RD_LAT-1:0]      vld_p;
    logic                   abort_act;
    logic                   issue_go;
    logic                   wdt_hit;

    // Columns left for bank b, clamped to [0, ARR_P]; 9-bit signed so that
    // banks past the end of sub_P come out as zero instead of wrapping.
    function automatic logic [7:0] bank_scale_p(input logic [7:0] p, input int b);
        logic signed [8:0] d;
        d = $signed({1'b0, p}) - $signed(9'(b * ARR_P));
        if (d < 9'sd0)
            return 8'd0;
        else if (d > $signed(9'(ARR_P)))
            return 8'(ARR_P);
        else
            return d[7:0];
    endfunction

    function automatic logic [ARR_M-1:0] lane_mask_f(input logic [7:0] m);
        logic [ARR_M-1:0] v;
        for (int i = 0; i < ARR_M; i++) v[i] = (i < int'(m));
        return v;
    endfunction

    function automatic logic [NUM_BANKS*ARR_P-1:0] lane_mask_w(input logic [7:0] p);
        logic [NUM_BANKS*ARR_P-1:0] v;
        for (int j = 0; j < NUM_BANKS * ARR_P; j++) v[j] = (j < int'(p));
        return v;
    endfunction

    assign busy      = (state != S_IDLE);
    assign abort_act = abort && busy;
    assign issue_go  = (state == S_ISSUE) && !stall && !abort_act;

    // Per-bank scale and "nothing to wait for" preset, plus sticky done merge
    always_comb begin
        scale_p_nxt = '0;
        done_pre    = '0;
        done_nxt    = done | bus.bank_get_all;
        for (int b = 0; b < NUM_BANKS; b++) begin
            scale_p_nxt[8*b +: 8] = bank_scale_p(sub_P, b);
            done_pre[b] = (sub_M == 8'd0) || (scale_p_nxt[8*b +: 8] == 8'd0);
        end
    end

    // Job sequencing, read issue, address generation and bank programming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            cfg_m           <= '0;
            cfg_p           <= '0;
            cfg_n           <= '0;
            issue_cnt       <= '0;
            fm_step         <= '0;
            wm_step         <= '0;
            done            <= '0;
            vld_p           <= '0;
            finish          <= 1'b0;
            bus.fm_addr     <= '0;
            bus.wm_addr     <= '0;
            bus.num_valid   <= 1'b0;
            bus.num_ori     <= '0;
            bus.sub_scale_M <= '0;
            bus.sub_scale_P <= '0;
        end else begin
            bus.num_valid <= 1'b0;
            finish        <= (state == S_FINISH) && !abort;
            vld_p[0]      <= issue_go;
            for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
            if (abort_act) begin
                state <= S_IDLE;
                vld_p <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state           <= S_INFO;
                            cfg_m           <= sub_M;
                            cfg_p           <= sub_P;
                            cfg_n           <= N;
                            issue_cnt       <= '0;
                            bus.fm_addr     <= F_BASE + ADDR_W'(subFM_addr) * F_MUL;
                            bus.wm_addr     <= W_BASE + ADDR_W'(subWM_addr) * W_MUL;
                            fm_step         <= ADDR_W'(subFM_incr) * F_MUL;
                            wm_step         <= ADDR_W'(subWM_incr) * W_MUL;
                            bus.num_valid   <= 1'b1;
                            bus.num_ori     <= N;
                            for (int b = 0; b < NUM_BANKS; b++)
                                bus.sub_scale_M[8*b +: 8] <= sub_M;
                            bus.sub_scale_P <= scale_p_nxt;
                            done            <= done_pre;
                        end
                    end
                    S_INFO: state <= (cfg_n == 16'd0) ? S_WAIT : S_ISSUE;
                    S_ISSUE: begin
                        done <= done_nxt;
                        if (!stall) begin
                            bus.fm_addr <= bus.fm_addr + fm_step;
                            bus.wm_addr <= bus.wm_addr + wm_step;
                            issue_cnt   <= issue_cnt + 16'd1;
                            if (issue_cnt == cfg_n - 16'd1) state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        done <= done_nxt;
                        if (vld_p == '0) state <= S_WAIT;
                    end
                    S_WAIT: begin
                        done <= done_nxt;
                        if ((&done_nxt) || wdt_hit) state <= S_FINISH;
                    end
                    S_FINISH: state <= S_IDLE;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

    // Capture the BRAM beat when its read token leaves the latency pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fdata  <= '0;
            bus.wdata  <= '0;
            bus.fvalid <= '0;
            bus.wvalid <= '0;
        end else if (vld_p[RD_LAT-1] && !abort_act) begin
            bus.fdata  <= bus.fm_rddata;
            bus.wdata  <= bus.wm_rddata;
            bus.fvalid <= lane_mask_f(cfg_m);
            bus.wvalid <= lane_mask_w(cfg_p);
        end else begin
            bus.fvalid <= '0;
            bus.wvalid <= '0;
        end
    end

`ifdef MULTI_CTRL_WDT_EN
    logic [15:0] wdt_cnt;

    assign wdt_hit = (state == S_WAIT) && (wdt_cnt == 16'(WDT_CYCLES - 1));

    // WAIT watchdog: count while waiting, flag a timeout until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            wdt_cnt <= (state == S_WAIT) ? wdt_cnt + 16'd1 : 16'd0;
            if (state == S_IDLE && start && !abort)
                err_timeout <= 1'b0;
            else if (wdt_hit && !abort_act)
                err_timeout <= 1'b1;
        end
    end
`else
    assign wdt_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_multiply_ctrl_banked.sv
// Directed bench for multiply_ctrl_banked with a beat scoreboard and a BRAM
// model whose read data encodes the address it was read from.
module tb_multiply_ctrl_banked;
    localparam int ARR_M = 8;
    localparam int ARR_P = 8;
    localparam int NB    = 2;
    localparam int RDL   = 3;
    localparam int AW    = 32;
    localparam int SF    = 0;
    localparam int SW    = 0;
    localparam int FI    = 8;
    localparam int WI    = 16;

    typedef struct {
        logic [31:0] fa;
        logic [31:0] wa;
        logic [7:0]  fv;
        logic [15:0] wv;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sub_M, sub_P;
    logic [15:0] N, subFM_addr, subFM_incr, subWM_addr, subWM_incr;
    logic        start, abort, stall;
    logic        busy, finish, err_timeout;

    multiply_ctrl_banked_if #(.ARR_M(ARR_M), .ARR_P(ARR_P), .NUM_BANKS(NB), .ADDR_W(AW)) bus ();

    multiply_ctrl_banked #(
        .ARR_M(ARR_M), .ARR_P(ARR_P), .NUM_BANKS(NB), .RD_LAT(RDL), .ADDR_W(AW),
        .SADDR_F(SF), .SADDR_W(SW), .F_INCR(FI), .W_INCR(WI), .WDT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sub_M(sub_M), .sub_P(sub_P), .N(N),
        .subFM_addr(subFM_addr), .subFM_incr(subFM_incr),
        .subWM_addr(subWM_addr), .subWM_incr(subWM_incr),
        .start(start), .abort(abort), .stall(stall),
        .busy(busy), .finish(finish), .err_timeout(err_timeout), .bus(bus)
    );

    int    n_cmp = 0;
    int    n_fail = 0;
    int    beats_seen = 0;
    int    fin_seen = 0;
    int    nv_seen = 0;
    logic [15:0] exp_n = '0;
    logic [15:0] exp_sm, exp_sp;
    beat_t exp_q[$];
    beat_t mon_e;
    logic [31:0] fa_h [RDL];
    logic [31:0] wa_h [RDL];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] fm_pat(input logic [31:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic logic [127:0] wm_pat(input logic [31:0] a);
        return {a, a ^ 32'hFFFF_0000, a + 32'd7, ~a};
    endfunction

    // BRAM: data for an address appears RDL cycles after it was presented
    always @(posedge clk) begin
        fa_h[0] <= bus.fm_addr;
        wa_h[0] <= bus.wm_addr;
        for (int i = 1; i < RDL; i++) begin
            fa_h[i] <= fa_h[i-1];
            wa_h[i] <= wa_h[i-1];
        end
    end
    assign bus.fm_rddata = fm_pat(fa_h[RDL-1]);
    assign bus.wm_rddata = wm_pat(wa_h[RDL-1]);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: address of read k, lane masks and per-bank column counts
    function automatic logic [31:0] model_addr(input int base, input int mul,
                                               input logic [15:0] idx, input logic [15:0] inc, input int k);
        return 32'(base) + (32'(idx) + 32'(k) * 32'(inc)) * 32'(mul);
    endfunction

    function automatic logic [7:0] fmask(input logic [7:0] m);
        if (int'(m) >= ARR_M) return 8'hFF;
        return 8'((1 << m) - 1);
    endfunction

    function automatic logic [15:0] wmask(input logic [7:0] p);
        if (int'(p) >= NB * ARR_P) return 16'hFFFF;
        return 16'((1 << p) - 1);
    endfunction

    function automatic logic [15:0] pack_sp(input logic [7:0] p);
        logic [15:0] r;
        int d;
        for (int b = 0; b < NB; b++) begin
            d = int'(p) - b * ARR_P;
            if (d < 0) d = 0;
            if (d > ARR_P) d = ARR_P;
            r[8*b +: 8] = 8'(d);
        end
        return r;
    endfunction

    task automatic model_job(input logic [7:0] m, p, input logic [15:0] n, fa, fi, wa, wi);
        beat_t e;
        exp_n  = n;
        exp_sm = {m, m};
        exp_sp = pack_sp(p);
        for (int k = 0; k < int'(n); k++) begin
            e.fa = model_addr(SF, FI, fa, fi, k);
            e.wa = model_addr(SW, WI, wa, wi, k);
            e.fv = fmask(m);
            e.wv = wmask(p);
            exp_q.push_back(e);
        end
    endtask

    // Compare process: every beat, finish and num_valid cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if ((|bus.fvalid) || (|bus.wvalid)) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_fdata", bus.fdata, fm_pat(mon_e.fa));
                    chk("beat_wdata", bus.wdata, wm_pat(mon_e.wa));
                    chk("beat_fvalid", bus.fvalid, mon_e.fv);
                    chk("beat_wvalid", bus.wvalid, mon_e.wv);
                end
            end
            if (finish) fin_seen++;
            if (bus.num_valid) begin
                nv_seen++;
                chk("num_ori", bus.num_ori, exp_n);
            end
        end
    end

    task automatic launch(input logic [7:0] m, p, input logic [15:0] n, fa, fi, wa, wi);
        sub_M = m; sub_P = p; N = n;
        subFM_addr = fa; subFM_incr = fi; subWM_addr = wa; subWM_incr = wi;
        start = 1'b1;
        model_job(m, p, n, fa, fi, wa, wi);
        step();
        start = 1'b0;
    endtask

    task automatic run_job(input logic [7:0] m, p, input logic [15:0] n, fa, fi, wa, wi,
                           input int st_at, st_len, input logic [1:0] early, late, input bit poke);
        int b0, f0, v0, c;
        b0 = beats_seen; f0 = fin_seen; v0 = nv_seen;
        launch(m, p, n, fa, fi, wa, wi);
        chk("info_busy", busy, 1);
        chk("info_num_valid", bus.num_valid, 1);
        chk("info_fm_addr", bus.fm_addr, model_addr(SF, FI, fa, fi, 0));
        chk("info_wm_addr", bus.wm_addr, model_addr(SW, WI, wa, wi, 0));
        chk("info_scale_M", bus.sub_scale_M, exp_sm);
        chk("info_scale_P", bus.sub_scale_P, exp_sp);
        c = 1;
        while (!((beats_seen - b0) >= int'(n) && c >= 4) && c < 300) begin
            stall = (c >= st_at && c < st_at + st_len);
            bus.bank_get_all = (c == 3) ? early : 2'b00;
            if (poke && c == 7) begin
                start = 1'b1;
                sub_M = ~m;
            end
            step();
            c++;
            stall = 1'b0; bus.bank_get_all = '0; start = 1'b0; sub_M = m;
        end
        chk("beat_count", beats_seen - b0, n);
        repeat (4) step();
        if (late != 2'b00) begin
            chk("no_early_finish", fin_seen - f0, 0);
            bus.bank_get_all = late;
            step();
            bus.bank_get_all = '0;
        end
        c = 0;
        while (fin_seen == f0 && c < 30) begin
            step();
            c++;
        end
        step(); step();
        chk("finish_count", fin_seen - f0, 1);
        chk("idle_busy", busy, 0);
        chk("num_valid_count", nv_seen - v0, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("err_timeout", err_timeout, 0);
    endtask

    task automatic run_abort();
        int b0, f0;
        b0 = beats_seen; f0 = fin_seen;
        launch(8'd8, 8'd16, 16'd6, 16'd1, 16'd1, 16'd2, 16'd1);
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        chk("abort_busy", busy, 0);
        repeat (10) step();
        chk("abort_no_beats", beats_seen - b0, 0);
        chk("abort_no_finish", fin_seen - f0, 0);
        chk("abort_scale_held", bus.sub_scale_P, 16'h0808);
    endtask

    task automatic run_async_reset();
        int b0;
        b0 = beats_seen;
        launch(8'd8, 8'd16, 16'd6, 16'd0, 16'd1, 16'd0, 16'd1);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_fvalid", bus.fvalid, 0);
        chk("arst_fm_addr", bus.fm_addr, 0);
        chk("arst_scale_M", bus.sub_scale_M, 0);
        chk("arst_num_ori", bus.num_ori, 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("arst_no_beats", beats_seen - b0, 0);
        chk("arst_idle", busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
        sub_M = '0; sub_P = '0; N = '0;
        subFM_addr = '0; subFM_incr = '0; subWM_addr = '0; subWM_incr = '0;
        bus.bank_get_all = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_finish", finish, 0);
        chk("rst_fvalid", bus.fvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_num_valid", bus.num_valid, 0);
        chk("rst_fm_addr", bus.fm_addr, 0);
        chk("rst_scale_P", bus.sub_scale_P, 0);
        chk("rst_err", err_timeout, 0);
        rst_n = 1'b1;
        step();

        // Hand-computed values that pin the model
        chk("pin_fa_k0", model_addr(SF, FI, 16'd2, 16'd1, 0), 32'd16);
        chk("pin_fa_k3", model_addr(SF, FI, 16'd2, 16'd1, 3), 32'd40);
        chk("pin_wa_k1", model_addr(SW, WI, 16'd0, 16'd1, 1), 32'd16);
        chk("pin_wa_k3", model_addr(SW, WI, 16'd0, 16'd1, 3), 32'd48);
        chk("pin_fv_m3", fmask(8'd3), 8'h07);
        chk("pin_wv_p5", wmask(8'd5), 16'h001F);
        chk("pin_wv_p16", wmask(8'd16), 16'hFFFF);
        chk("pin_sp_5", pack_sp(8'd5), 16'h0005);
        chk("pin_sp_12", pack_sp(8'd12), 16'h0408);

        // Full job, both banks pulsed in WAIT
        run_job(8'd8, 8'd16, 16'd4, 16'd2, 16'd1, 16'd0, 16'd1, 0, 0, 2'b00, 2'b11, 1'b0);
        // Partial geometry, bank1 pre-done
        run_job(8'd3, 8'd5, 16'd3, 16'd5, 16'd2, 16'd1, 16'd3, 0, 0, 2'b00, 2'b01, 1'b0);
        // Stall mid-issue, bank0 early, bank1 late, start ignored while busy
        run_job(8'd8, 8'd12, 16'd6, 16'd0, 16'd1, 16'd4, 16'd1, 3, 3, 2'b01, 2'b10, 1'b1);
        // N = 0
        run_job(8'd2, 8'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 0, 0, 2'b00, 2'b11, 1'b0);
        run_abort();
        run_async_reset();
        // Recovery with large index steps, single active bank
        run_job(8'd1, 8'd1, 16'd2, 16'hFFFF, 16'h0010, 16'h0003, 16'hFFFF, 0, 0, 2'b00, 2'b01, 1'b0);

`ifdef MULTI_CTRL_WDT_EN
        begin
            int f0, c;
            f0 = fin_seen;
            launch(8'd8, 8'd16, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1);
            c = 0;
            while (fin_seen == f0 && c < 80) begin
                step();
                c++;
            end
            chk("wdt_finish", fin_seen - f0, 1);
            chk("wdt_err", err_timeout, 1);
            step();
            launch(8'd8, 8'd16, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1);
            chk("wdt_err_cleared", err_timeout, 0);
            bus.bank_get_all = 2'b11;
            step();
            bus.bank_get_all = '0;
            c = 0;
            while (busy && c < 40) begin
                step();
                c++;
            end
            repeat (3) step();
            chk("wdt_second_idle", busy, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
